// File: rtl/lu_pkg.sv
// Shared opcodes and FSM encodings for the shared logic-unit arbiter.
package lu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/lu_core.sv
// Combinational 4-function bitwise logic unit; b is ignored for NOT.
module lu_core
  import lu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  always_comb begin
    s = '0;
    case (op)
      OP_AND:  s = a & b;
      OP_OR:   s = a | b;
      OP_XOR:  s = a ^ b;
      OP_NOT:  s = ~a;
      default: s = '0;
    endcase
  end

endmodule

// File: rtl/lu_share_arbiter.sv
// Round-robin sharing of one lu_core between two requesters, single tagged response channel.
//   state   | meaning
//   ST_IDLE | waiting for a request; grant drives reqN_ready
//   ST_EXEC | latched operands feed lu_core; result registered
//   ST_RESP | response held until rsp_ready
module lu_share_arbiter
  import lu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data
);

  state_t       state;
  logic         last_grant;
  logic [1:0]   op_q;
  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic         id_q;
  logic         grant_any;
  logic         grant_id;
  logic [W-1:0] lu_s;

  // On a tie the port that did not win last time goes next.
  assign grant_any  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
  assign req0_ready = rst_n & (state == ST_IDLE) & grant_any & ~grant_id;
  assign req1_ready = rst_n & (state == ST_IDLE) & grant_any &  grant_id;

  lu_core #(.W(W)) u_lu_core (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .s  (lu_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_any) begin
            op_q       <= grant_id ? req1_op : req0_op;
            a_q        <= grant_id ? req1_a  : req0_a;
            b_q        <= grant_id ? req1_b  : req0_b;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_data  <= lu_s;
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lu_share_arbiter.sv
// Directed bench for lu_share_arbiter: reset, op sweep, contention, backpressure, reset in flight.
module tb_lu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [3:0] rsp_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lu_share_arbiter #(.W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    #1;
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 1'b0) begin n_bad++; $display("FAIL rst_rsp_id: got %b want 0", rsp_id); end
    n_cmp++; if (rsp_data !== 4'b0000) begin n_bad++; $display("FAIL rst_rsp_data: got %b want 0000", rsp_data); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rst_ready: got %b want 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    rst_n = 1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL first_tie: got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 0;
    req1_op = 2'b10; req1_a = 4'b1100; req1_b = 4'b0110;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_bad++; $display("FAIL single_req1: got %b want 01", {req0_ready, req1_ready}); end
    @(negedge clk);
    req1_valid = 0;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_1_1010) begin n_bad++; $display("FAIL pre_rst_rsp: got %b want 111010", {rsp_valid, rsp_id, rsp_data}); end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b0) begin n_bad++; $display("FAIL async_rst: got %b want 000000", {rsp_valid, rsp_id, rsp_data}); end
    @(negedge clk);
    req0_valid = 1; req1_valid = 1;
    rst_n = 1;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_bad++; $display("FAIL tie_after_rst: got %b want 10", {req0_ready, req1_ready}); end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b00; req0_a = 4'b0011; req0_b = 4'b1010;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    n_cmp++; if ({rsp_valid, req0_ready} !== 2'b00) begin n_bad++; $display("FAIL single_exec: got %b want 00", {rsp_valid, req0_ready}); end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_0_0010) begin n_bad++; $display("FAIL single_rsp: got %b want 100010", {rsp_valid, rsp_id, rsp_data}); end
    rsp_ready = 1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", rsp_valid); end
    rsp_ready = 0;
  endtask

  task automatic test_ops_sweep();
    logic [3:0] exp_s [4];
    bit seen;
    exp_s[0] = 4'b0100; exp_s[1] = 4'b0111; exp_s[2] = 4'b0011; exp_s[3] = 4'b1001;
    rsp_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req1_valid = 1; req1_op = 2'(k); req1_a = 4'b0110; req1_b = 4'b0101;
      #1;
      n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL sweep_ready op%0d: got %b want 1", k, req1_ready); end
      @(negedge clk);
      req1_valid = 0;
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        @(negedge clk);
        if (rsp_valid) seen = 1;
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL sweep_timeout op%0d: got no rsp_valid want rsp_valid=1", k); end
      n_cmp++; if ({rsp_id, rsp_data} !== {1'b1, exp_s[k]}) begin n_bad++; $display("FAIL sweep_data op%0d: got id=%b data=%b want id=1 data=%b", k, rsp_id, rsp_data, exp_s[k]); end
      @(negedge clk);
    end
    rsp_ready = 0;
  endtask

  task automatic test_contention();
    int got = 0;
    int ids [4];
    int cyc [4];
    logic [3:0] dat [4];
    rsp_ready = 1;
    @(negedge clk);
    req0_valid = 1; req0_op = 2'b01; req0_a = 4'b0001; req0_b = 4'b0010;
    req1_valid = 1; req1_op = 2'b00; req1_a = 4'b1100; req1_b = 4'b0100;
    for (int i = 0; i < 20 && got < 4; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids[got] = int'(rsp_id); dat[got] = rsp_data; cyc[got] = i; got++;
      end
    end
    req0_valid = 0; req1_valid = 0;
    n_cmp++; if (got != 4) begin n_bad++; $display("FAIL cont_count: got %0d want 4", got); end
    for (int k = 0; k < got; k++) begin
      n_cmp++; if (ids[k] != k % 2) begin n_bad++; $display("FAIL cont_id%0d: got %0d want %0d", k, ids[k], k % 2); end
      n_cmp++; if (dat[k] !== ((k % 2) ? 4'b0100 : 4'b0011)) begin n_bad++; $display("FAIL cont_data%0d: got %b want %b", k, dat[k], (k % 2) ? 4'b0100 : 4'b0011); end
      if (k > 0) begin
        n_cmp++; if (cyc[k] - cyc[k-1] != 3) begin n_bad++; $display("FAIL cont_gap%0d: got %0d want 3", k, cyc[k] - cyc[k-1]); end
      end
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL cont_drain: got %b want 0", rsp_valid); end
    rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    rsp_ready = 0;
    req0_valid = 1; req0_op = 2'b10; req0_a = 4'b1010; req0_b = 4'b0110;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL bp_grant: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    req1_valid = 1; req1_op = 2'b11; req1_a = 4'b0000; req1_b = 4'b0000;
    #1;
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_exec_ready: got %b want 00", {req0_ready, req1_ready}); end
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if ({rsp_valid, rsp_id, rsp_data} !== 6'b1_0_1100) begin n_bad++; $display("FAIL bp_hold%0d: got %b want 101100", i, {rsp_valid, rsp_id, rsp_data}); end
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL bp_ready%0d: got %b want 00", i, {req0_ready, req1_ready}); end
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    n_cmp++; if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_waiter: got %b want 1", req1_ready); end
    req1_valid = 0;
    rsp_ready = 0;
  endtask

  task automatic test_reset_exec();
    bit stale = 0;
    bit seen = 0;
    @(negedge clk);
    req1_valid = 1; req1_op = 2'b01; req1_a = 4'b1000; req1_b = 4'b0001;
    @(posedge clk);
    #2;
    req1_valid = 0;
    rst_n = 0;
    #1;
    n_cmp++; if ({rsp_valid, req1_ready} !== 2'b00) begin n_bad++; $display("FAIL rexec_during: got %b want 00", {rsp_valid, req1_ready}); end
    @(negedge clk);
    rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) stale = 1;
    end
    n_cmp++; if (stale) begin n_bad++; $display("FAIL rexec_stale: got rsp_valid=1 want 0"); end
    rsp_ready = 1;
    req0_valid = 1; req0_op = 2'b00; req0_a = 4'b1111; req0_b = 4'b1001;
    #1;
    n_cmp++; if (req0_ready !== 1'b1) begin n_bad++; $display("FAIL rexec_regrant: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    n_cmp++; if ({seen, rsp_id, rsp_data} !== 6'b1_0_1001) begin n_bad++; $display("FAIL rexec_after: got %b want 101001", {seen, rsp_id, rsp_data}); end
    rsp_ready = 0;
  endtask

  initial begin
    req0_valid = 0; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    rsp_ready = 0;
    #1 rst_n = 0;
    test_reset();
    test_single();
    test_ops_sweep();
    test_contention();
    test_backpressure();
    test_reset_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
